// File: rtl/ddr3_pll_phase_ctrl.sv
// DDR3 CCC PLL sequencer: powerdown/lock qualification and conversion of phase-shift
// requests into timed PHASE_ROTATE / LOAD_PHASE_N pulse trains.
module ddr3_pll_phase_ctrl #(
   parameter int POWERDOWN_CYCLES = 16,
   parameter int LOCK_FILTER      = 8,
   parameter int ROTATE_PULSE     = 2,
   parameter int ROTATE_GAP       = 4
) (
   input  logic       SYS_CLK,
   input  logic       SYS_RESET_N,
   input  logic       PLL_LOCK,
   input  logic       RESTART,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic [2:0] REQ_SEL,
   input  logic       REQ_DIR,
   input  logic [7:0] REQ_STEPS,
   output logic       DONE,
   output logic       DONE_ERR,
   output logic       PLL_READY,
   output logic       LOCK_LOST,
   output logic       PLL_POWERDOWN_N,
   output logic       PHASE_OUT0_SEL,
   output logic       PHASE_OUT2_SEL,
   output logic       PHASE_OUT3_SEL,
   output logic       PHASE_DIRECTION,
   output logic       PHASE_ROTATE,
   output logic       LOAD_PHASE_N
);

   localparam int CW = 16;

   typedef enum logic [2:0] {
      ST_PWRDN, ST_WAIT_LOCK, ST_IDLE, ST_SETUP, ST_ROT_HI, ST_ROT_LO, ST_LOAD, ST_DONE
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [7:0]      rem_r, rem_s;
   logic [2:0]      sel_r, sel_s;
   logic            dir_lat_r, dir_lat_s;
   logic            lock_meta_r, lock_sync_r;
   logic            pwrdn_n_r, pwrdn_n_s;
   logic [2:0]      osel_r, osel_s;
   logic            dir_r, dir_s;
   logic            rot_r, rot_s;
   logic            load_n_r, load_n_s;
   logic            ready_r, ready_s;
   logic            done_r, done_s;
   logic            err_r, err_s;
   logic            pll_ready_r, pll_ready_s;
   logic            lost_r, lost_s;

   // Next state and next registered output values.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      rem_s       = rem_r;
      sel_s       = sel_r;
      dir_lat_s   = dir_lat_r;
      pwrdn_n_s   = 1'b1;
      osel_s      = 3'b000;
      dir_s       = dir_r;
      rot_s       = 1'b0;
      load_n_s    = 1'b1;
      ready_s     = 1'b0;
      done_s      = 1'b0;
      err_s       = 1'b0;
      pll_ready_s = pll_ready_r;
      lost_s      = 1'b0;
      case (state_r)
         ST_PWRDN: begin
            if (cnt_r == CW'(POWERDOWN_CYCLES)) begin
               state_s = ST_WAIT_LOCK;
               cnt_s   = {CW{1'b0}};
            end else begin
               pwrdn_n_s = 1'b0;
               cnt_s     = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_WAIT_LOCK: begin
            if (!lock_sync_r) begin
               cnt_s = {CW{1'b0}};
            end else if (cnt_r == CW'(LOCK_FILTER)) begin
               state_s     = ST_IDLE;
               cnt_s       = {CW{1'b0}};
               pll_ready_s = 1'b1;
               ready_s     = 1'b1;
            end else begin
               cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_IDLE: begin
            // Restart re-enters powerdown with the count pre-advanced so the low time is exact.
            if (RESTART) begin
               state_s     = ST_PWRDN;
               cnt_s       = {{(CW-1){1'b0}}, 1'b1};
               pwrdn_n_s   = 1'b0;
               pll_ready_s = 1'b0;
            end else if (REQ_VALID && ready_r) begin
               sel_s     = REQ_SEL;
               dir_lat_s = REQ_DIR;
               rem_s     = REQ_STEPS;
               cnt_s     = {CW{1'b0}};
               state_s   = (REQ_SEL == 3'b000) ? ST_DONE : ST_SETUP;
            end else begin
               ready_s = 1'b1;
            end
         end
         ST_SETUP: begin
            osel_s  = sel_r;
            dir_s   = dir_lat_r;
            cnt_s   = {CW{1'b0}};
            state_s = (rem_r == 8'd0) ? ST_LOAD : ST_ROT_HI;
         end
         ST_ROT_HI: begin
            osel_s = sel_r;
            rot_s  = 1'b1;
            if (cnt_r == CW'(ROTATE_PULSE - 1)) begin
               cnt_s   = {CW{1'b0}};
               state_s = ST_ROT_LO;
            end else begin
               cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_ROT_LO: begin
            osel_s = sel_r;
            if (cnt_r == CW'(ROTATE_GAP - 1)) begin
               cnt_s   = {CW{1'b0}};
               rem_s   = rem_r - 8'd1;
               state_s = (rem_r == 8'd1) ? ST_DONE : ST_ROT_HI;
            end else begin
               cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_LOAD: begin
            osel_s   = sel_r;
            load_n_s = 1'b0;
            if (cnt_r == CW'(ROTATE_PULSE - 1)) begin
               cnt_s   = {CW{1'b0}};
               state_s = ST_DONE;
            end else begin
               cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: begin
            osel_s  = sel_r;
            done_s  = 1'b1;
            state_s = ST_IDLE;
         end
         default: begin
            state_s     = ST_PWRDN;
            cnt_s       = {CW{1'b0}};
            pwrdn_n_s   = 1'b0;
            pll_ready_s = 1'b0;
         end
      endcase
      // Lock loss overrides everything from IDLE onward; an in-flight request ends in error.
      if (!lock_sync_r && (state_r inside {ST_IDLE, ST_SETUP, ST_ROT_HI, ST_ROT_LO, ST_LOAD, ST_DONE})) begin
         state_s     = ST_WAIT_LOCK;
         cnt_s       = {CW{1'b0}};
         pwrdn_n_s   = 1'b1;
         lost_s      = 1'b1;
         pll_ready_s = 1'b0;
         ready_s     = 1'b0;
         rot_s       = 1'b0;
         load_n_s    = 1'b1;
         osel_s      = 3'b000;
         done_s      = (state_r != ST_IDLE);
         err_s       = (state_r != ST_IDLE);
      end else begin
         lost_s = 1'b0;
      end
   end

   // State, counters, lock synchronizer and registered outputs.
   always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
      if (!SYS_RESET_N) begin
         state_r     <= ST_PWRDN;
         cnt_r       <= {CW{1'b0}};
         rem_r       <= 8'd0;
         sel_r       <= 3'b000;
         dir_lat_r   <= 1'b0;
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
         pwrdn_n_r   <= 1'b0;
         osel_r      <= 3'b000;
         dir_r       <= 1'b0;
         rot_r       <= 1'b0;
         load_n_r    <= 1'b1;
         ready_r     <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         pll_ready_r <= 1'b0;
         lost_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         rem_r       <= rem_s;
         sel_r       <= sel_s;
         dir_lat_r   <= dir_lat_s;
         // Lock is meaningless while the PLL is held powered down.
         lock_meta_r <= PLL_LOCK & pwrdn_n_s;
         lock_sync_r <= lock_meta_r;
         pwrdn_n_r   <= pwrdn_n_s;
         osel_r      <= osel_s;
         dir_r       <= dir_s;
         rot_r       <= rot_s;
         load_n_r    <= load_n_s;
         ready_r     <= ready_s;
         done_r      <= done_s;
         err_r       <= err_s;
         pll_ready_r <= pll_ready_s;
         lost_r      <= lost_s;
      end
   end

   assign REQ_READY       = ready_r;
   assign DONE            = done_r;
   assign DONE_ERR        = err_r;
   assign PLL_READY       = pll_ready_r;
   assign LOCK_LOST       = lost_r;
   assign PLL_POWERDOWN_N = pwrdn_n_r;
   assign PHASE_OUT0_SEL  = osel_r[0];
   assign PHASE_OUT2_SEL  = osel_r[1];
   assign PHASE_OUT3_SEL  = osel_r[2];
   assign PHASE_DIRECTION = dir_r;
   assign PHASE_ROTATE    = rot_r;
   assign LOAD_PHASE_N    = load_n_r;

endmodule

// File: tb/tb_ddr3_pll_phase_ctrl.sv
// Scoreboard bench for ddr3_pll_phase_ctrl: requests push expected completions,
// a negedge monitor pops them when DONE appears.
module tb_ddr3_pll_phase_ctrl;

   localparam int PC = 16;
   localparam int LF = 8;
   localparam int RP = 2;
   localparam int RG = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_lock = 1'b1;
   logic       restart = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_sel = 3'b000;
   logic       req_dir = 1'b0;
   logic [7:0] req_steps = 8'd0;
   logic       req_ready, done, done_err, pll_ready, lock_lost, pwrdn_n;
   logic       o0, o2, o3, pdir, prot, load_n;

   ddr3_pll_phase_ctrl #(.POWERDOWN_CYCLES(PC), .LOCK_FILTER(LF), .ROTATE_PULSE(RP), .ROTATE_GAP(RG)) dut (
      .SYS_CLK(clk), .SYS_RESET_N(rst_n), .PLL_LOCK(pll_lock), .RESTART(restart),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_SEL(req_sel), .REQ_DIR(req_dir),
      .REQ_STEPS(req_steps), .DONE(done), .DONE_ERR(done_err), .PLL_READY(pll_ready),
      .LOCK_LOST(lock_lost), .PLL_POWERDOWN_N(pwrdn_n), .PHASE_OUT0_SEL(o0),
      .PHASE_OUT2_SEL(o2), .PHASE_OUT3_SEL(o3), .PHASE_DIRECTION(pdir),
      .PHASE_ROTATE(prot), .LOAD_PHASE_N(load_n)
   );

   always #5 clk = ~clk;

   // Index of the most recent active edge after reset release (edge 0 is the first).
   int cyc = -1;
   always @(posedge clk) if (rst_n) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int       done_cyc;
      bit       err;
      int       rot_cyc;
      int       load_cyc;
      bit [2:0] sel;
      bit       dir;
      bit [2:0] done_sel;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   // Reference model: pin activity as offsets from the accept edge, truncated at an abort edge.
   function automatic int rot_cycles(input bit [2:0] sel, input int n, input int limit);
      int c = 0;
      if (sel != 3'b000)
         for (int i = 0; i < n; i++)
            for (int j = 0; j < RP; j++)
               if (2 + i * (RP + RG) + j < limit) c++;
      return c;
   endfunction

   function automatic int load_cycles(input bit [2:0] sel, input int n, input int limit);
      int c = 0;
      if (sel != 3'b000 && n == 0)
         for (int j = 0; j < RP; j++)
            if (2 + j < limit) c++;
      return c;
   endfunction

   function automatic int done_offset(input bit [2:0] sel, input int n);
      if (sel == 3'b000) return 1;
      if (n == 0) return 2 + RP;
      return 2 + n * (RP + RG);
   endfunction

   int rot_seen = 0, load_seen = 0, lost_seen = 0, lost_exp = 0;
   bit mon_en = 1'b0;

   // Monitor: pin activity accounting and scoreboard pop on every DONE.
   always @(negedge clk) begin
      if (mon_en) begin
         if (prot) rot_seen++;
         if (!load_n) load_seen++;
         if (lock_lost) lost_seen++;
         if (prot || !load_n) begin
            if (sb_q.size() == 0) check("pin_activity_without_request", 1, 0);
            else begin
               check("sel_during_pulse", {o3, o2, o0}, sb_q[0].sel);
               check("dir_during_pulse", pdir, sb_q[0].dir);
            end
         end
         if (req_ready) check("sel_zero_when_ready", {o3, o2, o0}, 0);
         if (done) begin
            if (sb_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
               mon_e = sb_q.pop_front();
               check("done_cycle", cyc, mon_e.done_cyc);
               check("done_err", done_err, mon_e.err);
               check("rotate_cycles", rot_seen, mon_e.rot_cyc);
               check("load_cycles", load_seen, mon_e.load_cyc);
               check("sel_at_done", {o3, o2, o0}, mon_e.done_sel);
            end
            rot_seen  = 0;
            load_seen = 0;
         end
      end
   end

   task automatic wait_edge(input int e);
      for (int i = 0; i < 2000 && cyc < e; i++) @(negedge clk);
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("ready_timeout", 0, 1);
   endtask

   // Issue one request; drop_off >= 1 drops PLL_LOCK after edge T+drop_off.
   task automatic do_request(input bit [2:0] sel, input bit dir, input int n, input int drop_off);
      bit   ok;
      int   t;
      exp_t x;
      wait_ready(ok);
      if (ok) begin
         req_valid = 1'b1;
         req_sel   = sel;
         req_dir   = dir;
         req_steps = 8'(n);
         t = cyc + 1;
         x.sel = sel;
         x.dir = dir;
         if (drop_off < 0) begin
            x.done_cyc = t + done_offset(sel, n);
            x.err      = 1'b0;
            x.rot_cyc  = rot_cycles(sel, n, 1 << 30);
            x.load_cyc = load_cycles(sel, n, 1 << 30);
            x.done_sel = sel;
         end else begin
            x.done_cyc = t + drop_off + 3;
            x.err      = 1'b1;
            x.rot_cyc  = rot_cycles(sel, n, drop_off + 3);
            x.load_cyc = load_cycles(sel, n, drop_off + 3);
            x.done_sel = 3'b000;
         end
         sb_q.push_back(x);
         @(negedge clk);
         check("ready_drops_on_accept", req_ready, 0);
         req_valid = 1'b0;
         @(negedge clk);
         if (sel != 3'b000) begin
            check("sel_at_t1", {o3, o2, o0}, sel);
            check("dir_at_t1", pdir, dir);
         end
         if (drop_off >= 1) begin
            repeat (drop_off - 1) @(negedge clk);
            pll_lock = 1'b0;
            repeat (3) @(negedge clk);
            lost_exp++;
            check("lock_lost_pulse", lock_lost, 1);
            check("pll_ready_after_loss", pll_ready, 0);
            check("rotate_low_after_loss", prot, 0);
            check("load_n_high_after_loss", load_n, 1);
         end else begin
            wait_ready(ok);
            check("ready_after_done", cyc, x.done_cyc + 1);
         end
      end
   endtask

   // Fatal bound in case the sequence itself stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t, k1, k2;
      repeat (3) @(negedge clk);
      check("rst_pwrdn_n", pwrdn_n, 0);
      check("rst_sels", {o3, o2, o0}, 0);
      check("rst_dir", pdir, 0);
      check("rst_rotate", prot, 0);
      check("rst_load_n", load_n, 1);
      check("rst_req_ready", req_ready, 0);
      check("rst_done", {done, done_err}, 0);
      check("rst_pll_ready", pll_ready, 0);
      check("rst_lock_lost", lock_lost, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      wait_edge(PC - 1);
      check("pwrdn_low_before", pwrdn_n, 0);
      wait_edge(PC);
      check("pwrdn_rise", pwrdn_n, 1);
      wait_edge(PC + LF + 1);
      check("ready_before_qual", {pll_ready, req_ready}, 2'b00);
      wait_edge(PC + LF + 2);
      check("ready_after_qual", {pll_ready, req_ready}, 2'b11);

      do_request(3'b010, 1'b1, 3, -1);
      do_request(3'b101, 1'b0, 0, -1);
      do_request(3'b000, 1'b1, 7, -1);
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_request(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 6), -1);
      end

      // Lock loss during the second rotate pulse, then a short glitch, then re-lock.
      do_request(3'b001, 1'b0, 5, 6);
      repeat (2) @(negedge clk);
      pll_lock = 1'b1;
      k1 = cyc + 1;
      repeat (5) @(negedge clk);
      pll_lock = 1'b0;
      repeat (3) @(negedge clk);
      pll_lock = 1'b1;
      k2 = cyc + 1;
      check("glitch_no_ready", pll_ready, 0);
      wait_edge(k2 + LF + 1);
      check("relock_before", pll_ready, 0);
      wait_edge(k2 + LF + 2);
      check("relock_ready", {pll_ready, req_ready}, 2'b11);
      check("glitch_start_sane", k2 - k1, 8);

      // RESTART together with REQ_VALID: restart wins.
      @(negedge clk);
      restart   = 1'b1;
      req_valid = 1'b1;
      req_sel   = 3'b001;
      req_steps = 8'd1;
      t = cyc + 1;
      @(negedge clk);
      restart   = 1'b0;
      req_valid = 1'b0;
      check("restart_ready_low", req_ready, 0);
      check("restart_pwrdn_low", pwrdn_n, 0);
      check("restart_pll_ready_low", pll_ready, 0);
      wait_edge(t + PC - 1);
      check("restart_pwrdn_still_low", pwrdn_n, 0);
      wait_edge(t + PC);
      check("restart_pwrdn_rise", pwrdn_n, 1);
      wait_edge(t + PC + LF + 1);
      check("restart_ready_before", pll_ready, 0);
      wait_edge(t + PC + LF + 2);
      check("restart_ready_after", {pll_ready, req_ready}, 2'b11);

      for (int i = 0; i < 5; i++)
         do_request(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 4), -1);

      repeat (4) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);
      check("lock_lost_count", lost_seen, lost_exp);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
